// File: rtl/sys_arr.sv
// sys_arr: weight-stationary N x N systolic MAC array; define SYS_ARR_SAT_EN for saturating adds
module sys_arr_pe (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic               wwrite,
  input  logic signed [7:0]  w_in,
  input  logic signed [7:0]  d_in,
  input  logic signed [15:0] s_in,
  output logic signed [7:0]  w,
  output logic signed [7:0]  d,
  output logic signed [15:0] s
);
  logic signed [15:0] prod;
  logic signed [15:0] mac;
  assign prod = 16'(d_in) * 16'(w);
`ifdef SYS_ARR_SAT_EN
  logic signed [16:0] sum;
  assign sum = 17'(s_in) + 17'(prod);
  assign mac = (sum[16] != sum[15]) ? (sum[16] ? 16'sh8000 : 16'sh7fff) : sum[15:0];
`else
  assign mac = s_in + prod;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      w <= '0;
      d <= '0;
      s <= '0;
    end else begin
      if (wwrite) w <= w_in;
      d <= d_in;
      s <= active ? mac : s_in;
    end
  end
endmodule

module sys_arr #(
  parameter int width_height = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       active,
  input  logic [8*width_height-1:0]  datain,
  input  logic [8*width_height-1:0]  win,
  input  logic [16*width_height-1:0] sumin,
  input  logic [width_height-1:0]    wwrite,
  output logic [16*width_height-1:0] maccout,
  output logic [8*width_height-1:0]  wout,
  output logic [width_height-1:0]    wwriteout,
  output logic [width_height-1:0]    activeout,
  output logic [8*width_height-1:0]  dataout
);
  localparam int N = width_height;
  logic signed [7:0]  w_q [N][N];
  logic signed [7:0]  d_q [N][N];
  logic signed [15:0] s_q [N][N];
  logic [N-1:0] act_sr;
  always_ff @(posedge clk) begin
    if (reset) begin
      act_sr    <= '0;
      wwriteout <= '0;
    end else begin
      act_sr    <= {act_sr[N-2:0], active};
      wwriteout <= wwrite;
    end
  end
  assign activeout = {N{act_sr[N-1]}};
  genvar r, c;
  generate
    for (r = 0; r < N; r++) begin : g_row
      for (c = 0; c < N; c++) begin : g_col
        logic signed [7:0]  wi;
        logic signed [7:0]  di;
        logic signed [15:0] si;
        if (r == 0) begin : g_top
          assign wi = win[8*c+:8];
          assign si = sumin[16*c+:16];
        end else begin : g_below
          assign wi = w_q[r-1][c];
          assign si = s_q[r-1][c];
        end
        if (c == 0) begin : g_left
          assign di = datain[8*r+:8];
        end else begin : g_right
          assign di = d_q[r][c-1];
        end
        sys_arr_pe u_pe (
          .clk    (clk),
          .reset  (reset),
          .active (active),
          .wwrite (wwrite[c]),
          .w_in   (wi),
          .d_in   (di),
          .s_in   (si),
          .w      (w_q[r][c]),
          .d      (d_q[r][c]),
          .s      (s_q[r][c])
        );
      end
    end
    for (c = 0; c < N; c++) begin : g_out
      assign maccout[16*c+:16] = s_q[N-1][c];
      assign wout[8*c+:8]      = w_q[N-1][c];
      assign dataout[8*c+:8]   = d_q[c][N-1];
    end
  endgenerate
endmodule

// File: tb/tb_sys_arr.sv
// tb_sys_arr: directed and random checks of sys_arr against a matrix-level reference model
module tb_sys_arr;
  localparam int N = 4;
  logic clk = 0;
  logic reset = 1;
  logic active = 0;
  logic [8*N-1:0] datain = '0, win = '0, dataout, wout;
  logic [16*N-1:0] sumin = '0, maccout;
  logic [N-1:0] wwrite = '0, wwriteout, activeout;
  int n_chk = 0, n_fail = 0;
  int mw [N][N];
  logic [8*N-1:0] dq[$];
  logic aq[$];
  logic [N-1:0] last_ww;

  sys_arr #(.width_height(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .datain    (datain),
    .win       (win),
    .sumin     (sumin),
    .wwrite    (wwrite),
    .maccout   (maccout),
    .wout      (wout),
    .wwriteout (wwriteout),
    .activeout (activeout),
    .dataout   (dataout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*N-1:0] wout_model();
    logic [8*N-1:0] res;
    for (int c = 0; c < N; c++) res[8*c+:8] = mw[N-1][c][7:0];
    return res;
  endfunction

  // column result = top sum plus dot product of the row activations with that column's weights
  function automatic logic [16*N-1:0] mac_model(input logic [8*N-1:0] din, input logic [16*N-1:0] s0, input logic act);
    logic [16*N-1:0] res;
    for (int c = 0; c < N; c++) begin
      int acc;
      acc = int'($signed(s0[16*c+:16]));
      if (act) begin
        for (int r = 0; r < N; r++) begin
          acc = acc + int'($signed(din[8*r+:8])) * mw[r][c];
`ifdef SYS_ARR_SAT_EN
          if (acc > 32767) acc = 32767;
          if (acc < -32768) acc = -32768;
`else
          acc = int'($signed(acc[15:0]));
`endif
        end
      end
      res[16*c+:16] = acc[15:0];
    end
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) begin
      foreach (mw[r, c]) mw[r][c] = 0;
      dq.delete();
      aq.delete();
      repeat (N) begin
        dq.push_back('0);
        aq.push_back(1'b0);
      end
      last_ww = '0;
    end else begin
      for (int c = 0; c < N; c++)
        if (wwrite[c]) begin
          for (int r = N-1; r > 0; r--) mw[r][c] = mw[r-1][c];
          mw[0][c] = int'($signed(win[8*c+:8]));
        end
      dq.push_back(datain);
      aq.push_back(active);
      if (dq.size() > N) void'(dq.pop_front());
      if (aq.size() > N) void'(aq.pop_front());
      last_ww = wwrite;
    end
    #1;
    chk("dataout", 64'(dataout), 64'(dq[0]));
    chk("activeout", 64'(activeout), 64'({N{aq[0]}}));
    chk("wwriteout", 64'(wwriteout), 64'(last_ww));
    chk("wout", 64'(wout), 64'(wout_model()));
  endtask

  initial begin
    logic [31:0] wl [4];
    wl[0] = 32'h0F0B0703; wl[1] = 32'h0E0A0602; wl[2] = 32'h0D090501; wl[3] = 32'h0C080400;
    reset = 1;
    active = 1'($urandom);
    datain = $urandom;
    win = $urandom;
    sumin = {$urandom, $urandom};
    wwrite = 4'($urandom);
    step();
    chk("rst_maccout", maccout, 64'h0);
    chk("rst_wout", 64'(wout), 64'h0);
    chk("rst_dataout", 64'(dataout), 64'h0);
    chk("rst_activeout", 64'(activeout), 64'h0);
    chk("rst_wwriteout", 64'(wwriteout), 64'h0);
    reset = 0;
    active = 0;
    wwrite = 4'hF;
    for (int i = 0; i < 4; i++) begin
      win = wl[i];
      step();
    end
    chk("wload_wout", 64'(wout), 64'h0F0B0703);
    chk("wload_wwriteout", 64'(wwriteout), 64'hF);
    wwrite = 4'h0;
    win = 32'hDEADBEEF;
    step();
    step();
    chk("whold_wout", 64'(wout), 64'h0F0B0703);
    chk("whold_wwriteout", 64'(wwriteout), 64'h0);
    datain = 32'h01010101;
    sumin = '0;
    active = 1;
    repeat (8) step();
    chk("mac_const", maccout, 64'h0036_0026_0016_0006);
    chk("mac_model", maccout, mac_model(datain, sumin, 1'b1));
    datain = 32'hFFFFFFFF;
    repeat (8) step();
    chk("signed_const", maccout, 64'hFFCA_FFDA_FFEA_FFFA);
    active = 0;
    sumin = {4{16'h1234}};
    for (int i = 0; i < 4; i++) begin
      datain = $urandom;
      step();
    end
    chk("pass_const", maccout, {4{16'h1234}});
    active = 1;
    step();
    active = 0;
    repeat (N-2) step();
    chk("pulse_early", 64'(activeout), 64'h0);
    step();
    chk("pulse_on", 64'(activeout), 64'hF);
    step();
    chk("pulse_off", 64'(activeout), 64'h0);
    for (int it = 0; it < 12; it++) begin
      active = 0;
      for (int i = 0; i < N; i++) begin
        wwrite = 4'($urandom);
        win = $urandom;
        datain = $urandom;
        step();
      end
      wwrite = '0;
      datain = $urandom;
      sumin = {$urandom, $urandom};
      active = 1'($urandom);
      repeat (2*N) step();
      chk("rand_mac", maccout, mac_model(datain, sumin, active));
    end
    active = 0;
    wwrite = 4'hF;
    win = 32'h7F7F7F7F;
    repeat (N) step();
    wwrite = '0;
    datain = 32'h7F7F7F7F;
    sumin = '0;
    active = 1;
    repeat (2*N) step();
`ifdef SYS_ARR_SAT_EN
    chk("ovf_const", maccout, {4{16'h7FFF}});
`else
    chk("ovf_const", maccout, {4{16'hFC04}});
`endif
    chk("ovf_model", maccout, mac_model(datain, sumin, 1'b1));
    reset = 1;
    step();
    chk("midrst_maccout", maccout, 64'h0);
    chk("midrst_wout", 64'(wout), 64'h0);
    chk("midrst_dataout", 64'(dataout), 64'h0);
    reset = 0;
    step();
    chk("postrst_maccout", maccout, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
